// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : cpu_pkg                                                         |
// | Shared types and constants for the single-cycle core: datapath width,     |
// | instruction field positions, Execute opcodes and the core FSM state type. |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
package cpu_pkg;

  localparam int XLEN   = 32;  // datapath / register width
  localparam int ILEN   = 32;  // instruction word width
  localparam int REG_AW = 5;   // register specifier width in the instruction

  // Instruction field bit positions
  localparam int OPC_MSB  = 6;
  localparam int OPC_LSB  = 0;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 7;
  localparam int FUNC_MSB = 15;
  localparam int FUNC_LSB = 12;
  localparam int RS1_MSB  = 20;
  localparam int RS1_LSB  = 16;
  localparam int RS2_MSB  = 25;
  localparam int RS2_LSB  = 21;
  localparam int IMM_MSB  = 31;
  localparam int IMM_LSB  = 21;
  localparam int IMM_W    = IMM_MSB - IMM_LSB + 1;

  // Opcodes; NOP is what HALT presents, the others are decoded by Execute
  localparam logic [6:0] OP_NOP = 7'b0000000;
  localparam logic [6:0] OP_EX1 = 7'b0000001;
  localparam logic [6:0] OP_EX2 = 7'b0000011;
  localparam logic [6:0] OP_EX3 = 7'b0000111;
  localparam logic [6:0] OP_EX4 = 7'b0001111;

  typedef enum logic {RUN, HALT} core_state_t;

  // True when the opcode is one that Execute acts on
  function automatic logic is_exec_opcode(input logic [6:0] op);
    return (op == OP_EX1) || (op == OP_EX2) || (op == OP_EX3) || (op == OP_EX4);
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_decode_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : fetch_decode_if                                               |
// | Bundles the fetch/decode stage's instruction-memory, Execute and status   |
// | signals.                                                                  |
// |   master : the fetch_decode stage (drives imem_addr, decode, status)      |
// |   slave  : the environment (instruction memory + Execute)                 |
// | Signals: imem_addr/imem_data, sonuc/we/pc_update/hata/resume from         |
// | Execute, rs1_data/rs2_data/imm/opcode/func to Execute, halted,            |
// | retired_cnt.                                                              |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
interface fetch_decode_if #(
  parameter int XLEN = cpu_pkg::XLEN
);
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_data;
  logic [XLEN-1:0] sonuc;
  logic            we;
  logic            pc_update;
  logic            hata;
  logic            resume;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [6:0]      opcode;
  logic [3:0]      func;
  logic            halted;
  logic [31:0]     retired_cnt;

  modport master (
    output imem_addr, rs1_data, rs2_data, imm, opcode, func, halted, retired_cnt,
    input  imem_data, sonuc, we, pc_update, hata, resume
  );

  modport slave (
    input  imem_addr, rs1_data, rs2_data, imm, opcode, func, halted, retired_cnt,
    output imem_data, sonuc, we, pc_update, hata, resume
  );
endinterface : fetch_decode_if
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : reg_file                                                        |
// | NREG x XLEN architectural register file, two asynchronous read ports and  |
// | one synchronous write port. x0 reads as zero and ignores writes.          |
// | Ports:                                                                    |
// |   clk, rst            clock, asynchronous active-high reset (clears all)  |
// |   raddr1_i/rdata1_o   read port 1                                         |
// |   raddr2_i/rdata2_o   read port 2                                         |
// |   we_i/waddr_i/wdata_i write port                                         |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module reg_file #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [cpu_pkg::REG_AW-1:0] raddr1_i,
  output logic [XLEN-1:0]           rdata1_o,
  input  logic [cpu_pkg::REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]           rdata2_o,
  input  logic                      we_i,
  input  logic [cpu_pkg::REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]           wdata_i
);
  import cpu_pkg::*;

  logic [XLEN-1:0] regs_q [NREG];

  // Reads return the pre-edge value: a write in the same cycle is not
  // forwarded, it becomes visible after the edge.
  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != '0) rdata1_o = regs_q[raddr1_i];
    if (raddr2_i != '0) rdata2_o = regs_q[raddr2_i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

endmodule : reg_file
`default_nettype wire

// File: rtl/fetch_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fetch_decode                                                    |
// | Fetch/decode stage of the single-cycle core. Holds the PC, slices the     |
// | fetched instruction, reads operands, writes back Execute results, picks   |
// | the next PC and halts on an Execute error until resume.                   |
// | Ports:                                                                    |
// |   clk  rising-edge clock                                                  |
// |   rst  asynchronous active-high reset                                     |
// |   bus  fetch_decode_if.master: imem_addr/imem_data, sonuc, we,            |
// |        pc_update, hata, resume in; rs1_data, rs2_data, imm, opcode, func, |
// |        halted, retired_cnt out                                            |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module fetch_decode #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input logic            clk,
  input logic            rst,
  fetch_decode_if.master bus
);
  import cpu_pkg::*;

  core_state_t       state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       retired_q, retired_d;
  logic              halted_q;

  logic [ILEN-1:0]   w_instr;
  logic [6:0]        w_opcode;
  logic [REG_AW-1:0] w_rd;
  logic [3:0]        w_func;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [IMM_W-1:0]  w_imm_raw;
  logic [XLEN-1:0]   w_rs1_val;
  logic [XLEN-1:0]   w_rs2_val;
  logic              w_rf_we;

  // Field slicing
  assign w_instr   = bus.imem_data;
  assign w_opcode  = w_instr[OPC_MSB:OPC_LSB];
  assign w_rd      = w_instr[RD_MSB:RD_LSB];
  assign w_func    = w_instr[FUNC_MSB:FUNC_LSB];
  assign w_rs1     = w_instr[RS1_MSB:RS1_LSB];
  assign w_rs2     = w_instr[RS2_MSB:RS2_LSB];
  assign w_imm_raw = w_instr[IMM_MSB:IMM_LSB];

  reg_file #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (w_rs1),
    .rdata1_o (w_rs1_val),
    .raddr2_i (w_rs2),
    .rdata2_o (w_rs2_val),
    .we_i     (w_rf_we),
    .waddr_i  (w_rd),
    .wdata_i  (bus.sonuc)
  );

  // Next state, next PC, retire counter and writeback enable.
  // An error in RUN takes priority over everything Execute asked for: the
  // faulting instruction neither writes nor redirects nor counts, so the PC
  // stays on it and it is re-fetched after resume.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    w_rf_we   = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.hata) begin
          state_d = HALT;
        end else begin
          w_rf_we   = bus.we && (w_rd != '0);
          pc_d      = bus.pc_update ? bus.sonuc : (pc_q + XLEN'(PC_STEP));
          retired_d = retired_q + 32'd1;
        end
      end
      HALT: begin
        if (bus.resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      halted_q  <= (state_d == HALT);
    end
  end

  // Decode outputs; HALT presents a NOP with all operands zeroed so Execute
  // sees nothing to act on while the core is stopped.
  always_comb begin
    bus.imem_addr   = pc_q;
    bus.halted      = halted_q;
    bus.retired_cnt = retired_q;
    bus.opcode      = OP_NOP;
    bus.func        = '0;
    bus.imm         = '0;
    bus.rs1_data    = '0;
    bus.rs2_data    = '0;
    if (state_q == RUN) begin
      bus.opcode   = w_opcode;
      bus.func     = w_func;
      bus.imm      = {{(XLEN-IMM_W){w_imm_raw[IMM_W-1]}}, w_imm_raw};
      bus.rs1_data = w_rs1_val;
      bus.rs2_data = w_rs2_val;
    end
  end

endmodule : fetch_decode
`default_nettype wire
